// File: rtl/aligner_pkg.sv
// Lane state encoding and width helper for the multi-lane bitslip aligner.
// Combinational helpers only; no clocked logic and no handshake.
package aligner_pkg;

  typedef enum logic [1:0] {
    ST_MONITOR = 2'd0,
    ST_SLIP    = 2'd1,
    ST_DET_RST = 2'd2,
    ST_SETTLE  = 2'd3
  } lane_state_e;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_lane_aligner_if.sv
// Per-lane alignment bus: misalignment pulses in; slip, detector reset, lock, slip index, fail out.
// Plain level signals with no flow control; LANES=1 instances connect a single lane.
interface multi_lane_aligner_if #(
  parameter int LANES = 4,
  parameter int SW    = 4
);
  logic [LANES-1:0]    n_align;
  logic [LANES-1:0]    align;
  logic [LANES-1:0]    detector_rst;
  logic [LANES-1:0]    locked;
  logic [LANES-1:0]    fail;
  logic [LANES*SW-1:0] slip_pos;

  modport master (output n_align, input align, detector_rst, locked, fail, slip_pos);
  modport slave  (input n_align, output align, detector_rst, locked, fail, slip_pos);
endinterface

// File: rtl/aligner_lane.sv
// One alignment lane: MONITOR -> SLIP (1 cycle) -> DET_RST -> SETTLE -> MONITOR; align 1 cycle after pulse.
// No backpressure: pulses outside MONITOR are dropped. ALIGNER_SWEEP_TIMEOUT_EN adds the 2-sweep fail stop.
module aligner_lane import aligner_pkg::*; #(
  parameter int SLIP_POSITIONS = 10,
  parameter int DET_RST_CYCLES = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int LOCK_CYCLES    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multi_lane_aligner_if.slave   bus
);

  localparam int TMAX = (DET_RST_CYCLES > SETTLE_CYCLES) ? DET_RST_CYCLES : SETTLE_CYCLES;
  localparam int TW   = width_of(TMAX);
  localparam int CW   = width_of(LOCK_CYCLES + 1);
  localparam int PW   = width_of(SLIP_POSITIONS);

  lane_state_e   state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [PW-1:0] pos, pos_nx;
  logic          slip_go;
  logic          cnt_full;
  logic          locked;
  logic          fail_q;

  assign cnt_full = (cnt == CW'(LOCK_CYCLES));
  assign locked   = (state == ST_MONITOR) && cnt_full;

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    cnt_nx   = '0;
    pos_nx   = pos;
    slip_go  = 1'b0;
    unique case (state)
      ST_MONITOR: begin
        if (bus.n_align[0]) begin
          if (!fail_q) begin
            state_nx = ST_SLIP;
            slip_go  = 1'b1;
            pos_nx   = (pos == PW'(SLIP_POSITIONS - 1)) ? '0 : pos + 1'b1;
          end
        end else begin
          cnt_nx = cnt_full ? cnt : cnt + 1'b1;
        end
      end
      ST_SLIP: begin
        state_nx = ST_DET_RST;
        timer_nx = '0;
      end
      ST_DET_RST: begin
        if (timer == TW'(DET_RST_CYCLES - 1)) begin
          state_nx = ST_SETTLE;
          timer_nx = '0;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (timer == TW'(SETTLE_CYCLES - 1)) begin
          state_nx = ST_MONITOR;
          timer_nx = '0;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: begin
        state_nx = ST_DET_RST;
        timer_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_DET_RST;
      timer <= '0;
      cnt   <= '0;
      pos   <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      cnt   <= cnt_nx;
      pos   <= pos_nx;
    end
  end

`ifdef ALIGNER_SWEEP_TIMEOUT_EN
  // A sweep is one wrap of the slip index; the second wrap without lock parks the lane.
  logic [1:0] sweeps, sweeps_nx;
  logic       fail_nx;

  always_comb begin
    sweeps_nx = locked ? 2'd0 : sweeps;
    fail_nx   = fail_q;
    if (slip_go && (pos == PW'(SLIP_POSITIONS - 1))) begin
      if (sweeps_nx == 2'd1) fail_nx = 1'b1;
      if (sweeps_nx != 2'd2) sweeps_nx = sweeps_nx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweeps <= 2'd0;
      fail_q <= 1'b0;
    end else begin
      sweeps <= sweeps_nx;
      fail_q <= fail_nx;
    end
  end
`else
  assign fail_q = 1'b0;
`endif

  assign bus.align        = (state == ST_SLIP);
  assign bus.detector_rst = (state == ST_DET_RST);
  assign bus.locked       = locked;
  assign bus.slip_pos     = pos;
  assign bus.fail         = fail_q;

endmodule

// File: rtl/multi_lane_aligner.sv
// LANES independent bitslip aligners plus a registered all-locked flag (1 cycle behind the lane AND).
// No backpressure; ALIGNER_SWEEP_TIMEOUT_EN enables per-lane fail_o, otherwise fail_o is constant 0.
module multi_lane_aligner import aligner_pkg::*; #(
  parameter  int LANES          = 4,
  parameter  int SLIP_POSITIONS = 10,
  parameter  int DET_RST_CYCLES = 4,
  parameter  int SETTLE_CYCLES  = 16,
  parameter  int LOCK_CYCLES    = 64,
  localparam int SW             = width_of(SLIP_POSITIONS)
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [LANES-1:0]    n_align_i,
  output logic [LANES-1:0]    align_o,
  output logic [LANES-1:0]    detector_rst_o,
  output logic [LANES-1:0]    locked_o,
  output logic [LANES*SW-1:0] slip_pos_o,
  output logic                all_locked_o,
  output logic [LANES-1:0]    fail_o
);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    multi_lane_aligner_if #(.LANES(1), .SW(SW)) lane_bus ();

    assign lane_bus.n_align = n_align_i[l];

    aligner_lane #(
      .SLIP_POSITIONS (SLIP_POSITIONS),
      .DET_RST_CYCLES (DET_RST_CYCLES),
      .SETTLE_CYCLES  (SETTLE_CYCLES),
      .LOCK_CYCLES    (LOCK_CYCLES)
    ) u_lane (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .bus   (lane_bus.slave)
    );

    assign align_o[l]              = lane_bus.align[0];
    assign detector_rst_o[l]       = lane_bus.detector_rst[0];
    assign locked_o[l]             = lane_bus.locked[0];
    assign fail_o[l]               = lane_bus.fail[0];
    assign slip_pos_o[l*SW +: SW]  = lane_bus.slip_pos;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) all_locked_o <= 1'b0;
    else            all_locked_o <= &locked_o;
  end

endmodule

// File: tb/tb_multi_lane_aligner.sv
// Self-checking bench: timeline reference model of each lane (slip/detector/monitor windows in absolute cycles).
module tb_multi_lane_aligner;
  import aligner_pkg::*;

  localparam int LANES = 4;
  localparam int P     = 10;
  localparam int D     = 4;
  localparam int S     = 16;
  localparam int L     = 64;
  localparam int SW    = width_of(P);
  localparam int W     = 4*LANES + LANES*SW + 1;
`ifdef ALIGNER_SWEEP_TIMEOUT_EN
  localparam bit SWEEP_EN = 1'b1;
`else
  localparam bit SWEEP_EN = 1'b0;
`endif
  localparam logic [W-1:0] RST_VEC = {{LANES{1'b0}}, {LANES{1'b1}}, {LANES{1'b0}},
                                      {(LANES*SW){1'b0}}, {LANES{1'b0}}, 1'b0};

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic all_locked;

  multi_lane_aligner_if #(.LANES(LANES), .SW(SW)) bus ();

  multi_lane_aligner #(
    .LANES(LANES), .SLIP_POSITIONS(P), .DET_RST_CYCLES(D),
    .SETTLE_CYCLES(S), .LOCK_CYCLES(L)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .n_align_i      (bus.n_align),
    .align_o        (bus.align),
    .detector_rst_o (bus.detector_rst),
    .locked_o       (bus.locked),
    .slip_pos_o     (bus.slip_pos),
    .all_locked_o   (all_locked),
    .fail_o         (bus.fail)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int mon_start[LANES];
  int slip_cyc[LANES];
  int det_start[LANES];
  int pos[LANES];
  int cnt[LANES];
  int sweeps[LANES];
  bit mfail[LANES];
  logic [LANES-1:0]    exp_align, exp_det, exp_locked, exp_fail;
  logic [LANES*SW-1:0] exp_pos;
  logic                exp_all;

  function automatic logic [W-1:0] observed();
    return {bus.align, bus.detector_rst, bus.locked, bus.slip_pos, bus.fail, all_locked};
  endfunction

  function automatic logic [W-1:0] expected();
    return {exp_align, exp_det, exp_locked, exp_pos, exp_fail, exp_all};
  endfunction

  function automatic void model_outputs();
    for (int l = 0; l < LANES; l++) begin
      exp_align[l]         = (cyc == slip_cyc[l]);
      exp_det[l]           = (cyc >= det_start[l]) && (cyc < det_start[l] + D);
      exp_locked[l]        = (cyc >= mon_start[l]) && (cnt[l] == L);
      exp_pos[l*SW +: SW]  = SW'(pos[l]);
      exp_fail[l]          = mfail[l];
      if (exp_locked[l]) sweeps[l] = 0;
    end
  endfunction

  function automatic void model_reset();
    cyc = 0;
    for (int l = 0; l < LANES; l++) begin
      mon_start[l] = D + S;
      slip_cyc[l]  = -1000;
      det_start[l] = 0;
      pos[l]       = 0;
      cnt[l]       = 0;
      sweeps[l]    = 0;
      mfail[l]     = 1'b0;
    end
    exp_all = 1'b0;
    model_outputs();
  endfunction

  // Present na for the current cycle, advance one clock, update the model, sample 1ns later.
  task automatic step(input logic [LANES-1:0] na);
    logic [LANES-1:0] prev_locked;
    bus.n_align = na;
    @(posedge sys_clk);
    prev_locked = exp_locked;
    for (int l = 0; l < LANES; l++) begin
      if (cyc >= mon_start[l]) begin
        if (na[l]) begin
          cnt[l] = 0;
          if (!mfail[l]) begin
            slip_cyc[l]  = cyc + 1;
            det_start[l] = cyc + 2;
            mon_start[l] = cyc + 2 + D + S;
            pos[l]       = (pos[l] + 1) % P;
            if (SWEEP_EN && pos[l] == 0) begin
              sweeps[l]++;
              if (sweeps[l] >= 2) mfail[l] = 1'b1;
            end
          end
        end else if (cnt[l] < L) begin
          cnt[l]++;
        end
      end else begin
        cnt[l] = 0;
      end
    end
    cyc++;
    exp_all = &prev_locked;
    model_outputs();
    #1;
  endtask

  task automatic test_reset();
    bus.n_align = '0;
    sys_rst_n   = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    n_cmp++; if (bus.align !== 4'h0)         begin n_err++; $display("FAIL reset_align got=%b exp=0000", bus.align); end
    n_cmp++; if (bus.detector_rst !== 4'hF)  begin n_err++; $display("FAIL reset_det got=%b exp=1111", bus.detector_rst); end
    n_cmp++; if (bus.locked !== 4'h0)        begin n_err++; $display("FAIL reset_locked got=%b exp=0000", bus.locked); end
    n_cmp++; if (bus.slip_pos !== 16'h0)     begin n_err++; $display("FAIL reset_pos got=%h exp=0000", bus.slip_pos); end
    n_cmp++; if (all_locked !== 1'b0)        begin n_err++; $display("FAIL reset_all got=%b exp=0", all_locked); end
    n_cmp++; if (bus.fail !== 4'h0)          begin n_err++; $display("FAIL reset_fail got=%b exp=0000", bus.fail); end
    sys_rst_n = 1'b1;
    model_reset();
    n_cmp++; if (observed() !== expected()) begin n_err++; $display("FAIL release_cyc0 got=%h exp=%h", observed(), expected()); end
  endtask

  task automatic test_lock_acquire();
    for (int i = 0; i < 90; i++) begin
      step('0);
      n_cmp++; if (observed() !== expected()) begin n_err++; $display("FAIL lock_seq cyc=%0d got=%h exp=%h", cyc, observed(), expected()); end
      if (cyc == 3) begin
        n_cmp++; if (bus.detector_rst !== 4'hF) begin n_err++; $display("FAIL det_last cyc=3 got=%b exp=1111", bus.detector_rst); end
      end
      if (cyc == 4) begin
        n_cmp++; if (bus.detector_rst !== 4'h0) begin n_err++; $display("FAIL det_end cyc=4 got=%b exp=0000", bus.detector_rst); end
      end
      if (cyc == 83) begin
        n_cmp++; if (bus.locked !== 4'h0) begin n_err++; $display("FAIL lock_early cyc=83 got=%b exp=0000", bus.locked); end
      end
      if (cyc == 84) begin
        n_cmp++; if (bus.locked !== 4'hF || all_locked !== 1'b0) begin n_err++; $display("FAIL lock_rise cyc=84 got=%b/%b exp=1111/0", bus.locked, all_locked); end
      end
      if (cyc == 85) begin
        n_cmp++; if (all_locked !== 1'b1) begin n_err++; $display("FAIL all_locked cyc=85 got=%b exp=1", all_locked); end
      end
    end
  endtask

  task automatic test_single_slip();
    int pulses = 0;
    for (int i = 0; i < 45; i++) begin
      step((i < 5) ? 4'b0001 : 4'b0000);
      if (bus.align[0]) pulses++;
      n_cmp++; if (observed() !== expected()) begin n_err++; $display("FAIL single_slip cyc=%0d got=%h exp=%h", cyc, observed(), expected()); end
    end
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL slip_count got=%0d exp=1", pulses); end
    n_cmp++; if (bus.slip_pos[SW-1:0] !== 4'd1) begin n_err++; $display("FAIL slip_pos0 got=%0d exp=1", bus.slip_pos[SW-1:0]); end
    n_cmp++; if (bus.locked[3:1] !== 3'b111) begin n_err++; $display("FAIL others_locked got=%b exp=111", bus.locked[3:1]); end
  endtask

  task automatic test_simultaneous();
    step(4'b1001);
    n_cmp++; if (bus.align !== 4'b1001) begin n_err++; $display("FAIL simul_align got=%b exp=1001", bus.align); end
    for (int i = 0; i < 30; i++) begin
      step('0);
      n_cmp++; if (observed() !== expected()) begin n_err++; $display("FAIL simul cyc=%0d got=%h exp=%h", cyc, observed(), expected()); end
    end
  endtask

  task automatic test_wrap();
    logic [SW-1:0] want;
    for (int k = 1; k <= 10; k++) begin
      int len = $urandom_range(1, 3);
      for (int i = 0; i < 25; i++) begin
        step((i < len) ? 4'b0100 : 4'b0000);
        n_cmp++; if (observed() !== expected()) begin n_err++; $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, observed(), expected()); end
      end
      want = SW'(k % P);
      n_cmp++; if (bus.slip_pos[2*SW +: SW] !== want) begin n_err++; $display("FAIL wrap_pos k=%0d got=%0d exp=%0d", k, bus.slip_pos[2*SW +: SW], want); end
    end
  endtask

  task automatic test_random();
    logic [LANES-1:0] na;
    for (int i = 0; i < 400; i++) begin
      for (int l = 0; l < LANES; l++) na[l] = ($urandom_range(0, 15) == 0);
      step(na);
      n_cmp++; if (observed() !== expected()) begin n_err++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, observed(), expected()); end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      sys_rst_n = 1'b0;
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;
      model_reset();
      repeat (D + S) step('0);
      step(4'b0010);
      n_cmp++; if (observed() !== expected()) begin n_err++; $display("FAIL mid_slip k=%0d got=%h exp=%h", k, observed(), expected()); end
      if (k == 1) step('0);
      sys_rst_n = 1'b0;
      #1;
      n_cmp++; if (observed() !== RST_VEC) begin n_err++; $display("FAIL mid_reset k=%0d got=%h exp=%h", k, observed(), RST_VEC); end
      repeat (2) @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 30; i++) begin
        step((i == 22) ? 4'b0010 : 4'b0000);
        n_cmp++; if (observed() !== expected()) begin n_err++; $display("FAIL mid_restart k=%0d cyc=%0d got=%h exp=%h", k, cyc, observed(), expected()); end
      end
    end
  endtask

  task automatic test_sweep_timeout();
    int pulses = 0;
    int want = SWEEP_EN ? 20 : 22;
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    model_reset();
    repeat (D + S) step('0);
    for (int p = 0; p < 22; p++) begin
      for (int i = 0; i < 30; i++) begin
        step((i == 0) ? 4'b0010 : 4'b0000);
        if (bus.align[1]) pulses++;
        n_cmp++; if (observed() !== expected()) begin n_err++; $display("FAIL sweep cyc=%0d got=%h exp=%h", cyc, observed(), expected()); end
      end
    end
    n_cmp++; if (pulses != want) begin n_err++; $display("FAIL sweep_slips got=%0d exp=%0d", pulses, want); end
    n_cmp++; if (bus.fail[1] !== SWEEP_EN) begin n_err++; $display("FAIL sweep_fail got=%b exp=%b", bus.fail[1], SWEEP_EN); end
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_single_slip();
    test_simultaneous();
    test_wrap();
    test_random();
    test_reset_mid();
    test_sweep_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
